// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: parser state encoding and error codes shared with the command decoder.
// The CHK state exists only when UART_FRAME_CHKSUM_EN is defined.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_ADDR = 3'd2,
        S_PAY  = 3'd3,
        S_TAIL = 3'd4
`ifdef UART_FRAME_CHKSUM_EN
        , S_CHK = 3'd5
`endif
    } state_e;

    localparam logic [1:0] ERR_LEN     = 2'd0;
    localparam logic [1:0] ERR_TAIL    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_CHK     = 2'd3;

endpackage

// File: rtl/uart_frame_timer.sv
// uart_frame_timer: inter-byte timeout counter. Counts while enabled, clears on
// every received byte (or while disabled) and saturates at the limit so expire_o
// stays high until the parser reacts.
module uart_frame_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 50_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic expire_o
);

    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES);

    logic [W-1:0] cnt_q;

    // Idle-cycle counter: cleared by a byte or outside a frame, saturating at LIMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i || !en_i) begin
            cnt_q <= '0;
        end else if (cnt_q != LIMIT) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expire_o = en_i && (cnt_q == LIMIT);

endmodule

// File: rtl/uart_frame_parser.sv
// uart_frame_parser: HEAD | LEN | ADDR | PAYLOAD | [CHK] | END byte-stream parser.
// Define UART_FRAME_CHKSUM_EN to compile in the XOR checksum byte before the tail.
// Payload bytes are streamed before the frame is verified; consumers discard on frame_err.
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter int unsigned ADDR_BYTES     = 1,
    parameter int unsigned MAX_PAYLOAD    = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50_000,
    parameter logic [7:0]  HEAD_FRAME     = 8'hA6,
    parameter logic [7:0]  END_FRAME      = 8'hCE
) (
    input  logic                              sys_clk,
    input  logic                              sys_rst_n,
    input  logic                              rx_valid,
    input  logic [7:0]                        rx_data,
    output logic [8*ADDR_BYTES-1:0]           addr_data,
    output logic                              addr_valid,
    output logic [7:0]                        pay_data,
    output logic                              pay_valid,
    output logic [$clog2(MAX_PAYLOAD+1)-1:0]  pay_index,
    output logic                              pay_last,
    output logic                              frame_done,
    output logic                              frame_err,
    output logic [1:0]                        err_code
);

    localparam int         AW      = 8 * ADDR_BYTES;
    localparam int         PIW     = $clog2(MAX_PAYLOAD + 1);
    localparam logic [8:0] LEN_MIN = 9'(ADDR_BYTES + 1);
    localparam logic [8:0] LEN_MAX = 9'(ADDR_BYTES + MAX_PAYLOAD);
    localparam logic [7:0] AB8     = 8'(ADDR_BYTES);

    state_e           state_q, state_d;
    logic [7:0]       pay_cnt_q, pay_cnt_d;
    logic [7:0]       idx_q, idx_d;
    logic [AW-1:0]    addr_sh_q, addr_sh_d;
    logic [AW-1:0]    addr_data_q, addr_data_d;
    logic             addr_valid_q, addr_valid_d;
    logic [7:0]       pay_data_q, pay_data_d;
    logic             pay_valid_q, pay_valid_d;
    logic [PIW-1:0]   pay_index_q, pay_index_d;
    logic             pay_last_q, pay_last_d;
    logic             frame_done_q, frame_done_d;
    logic             frame_err_q, frame_err_d;
    logic [1:0]       err_code_q, err_code_d;
`ifdef UART_FRAME_CHKSUM_EN
    logic [7:0]       chk_q, chk_d;
`endif

    logic             expire;
    logic [AW-1:0]    addr_next;
    logic [7:0]       idx_inc;

    assign addr_next = AW'({addr_sh_q, rx_data});
    assign idx_inc   = idx_q + 8'd1;

    uart_frame_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (sys_clk),
        .rst_n    (sys_rst_n),
        .en_i     (state_q != S_IDLE),
        .clr_i    (rx_valid),
        .expire_o (expire)
    );

    // Next-state and registered-output decode; a received byte takes priority over timeout.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d      = state_q;
        pay_cnt_d    = pay_cnt_q;
        idx_d        = idx_q;
        addr_sh_d    = addr_sh_q;
        addr_data_d  = addr_data_q;
        pay_data_d   = pay_data_q;
        pay_index_d  = pay_index_q;
        err_code_d   = err_code_q;
        addr_valid_d = 1'b0;
        pay_valid_d  = 1'b0;
        pay_last_d   = 1'b0;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
`ifdef UART_FRAME_CHKSUM_EN
        chk_d        = chk_q;
`endif

        if (rx_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (rx_data == HEAD_FRAME) state_d = S_LEN;
                end
                S_LEN: begin
                    if (({1'b0, rx_data} < LEN_MIN) || ({1'b0, rx_data} > LEN_MAX)) begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_LEN;
                        state_d     = S_IDLE;
                    end else begin
                        pay_cnt_d = rx_data - AB8;
                        idx_d     = '0;
                        state_d   = S_ADDR;
`ifdef UART_FRAME_CHKSUM_EN
                        chk_d     = rx_data;
`endif
                    end
                end
                S_ADDR: begin
                    addr_sh_d = addr_next;
`ifdef UART_FRAME_CHKSUM_EN
                    chk_d     = chk_q ^ rx_data;
`endif
                    if (idx_inc == AB8) begin
                        addr_data_d  = addr_next;
                        addr_valid_d = 1'b1;
                        idx_d        = '0;
                        state_d      = S_PAY;
                    end else begin
                        idx_d = idx_inc;
                    end
                end
                S_PAY: begin
                    pay_data_d  = rx_data;
                    pay_index_d = idx_q[PIW-1:0];
                    pay_valid_d = 1'b1;
                    idx_d       = idx_inc;
`ifdef UART_FRAME_CHKSUM_EN
                    chk_d       = chk_q ^ rx_data;
`endif
                    if (idx_inc == pay_cnt_q) begin
                        pay_last_d = 1'b1;
`ifdef UART_FRAME_CHKSUM_EN
                        state_d    = S_CHK;
`else
                        state_d    = S_TAIL;
`endif
                    end
                end
`ifdef UART_FRAME_CHKSUM_EN
                S_CHK: begin
                    if (rx_data == chk_q) begin
                        state_d = S_TAIL;
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_CHK;
                        state_d     = S_IDLE;
                    end
                end
`endif
                S_TAIL: begin
                    // A HEAD_FRAME byte here is just a bad tail, never a new header.
                    if (rx_data == END_FRAME) begin
                        frame_done_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_TAIL;
                    end
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (expire) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_TIMEOUT;
            state_d     = S_IDLE;
        end
    end

    // State and output registers; reset aborts any frame silently.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= S_IDLE;
            pay_cnt_q    <= '0;
            idx_q        <= '0;
            addr_sh_q    <= '0;
            addr_data_q  <= '0;
            addr_valid_q <= 1'b0;
            pay_data_q   <= '0;
            pay_valid_q  <= 1'b0;
            pay_index_q  <= '0;
            pay_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            err_code_q   <= '0;
`ifdef UART_FRAME_CHKSUM_EN
            chk_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            pay_cnt_q    <= pay_cnt_d;
            idx_q        <= idx_d;
            addr_sh_q    <= addr_sh_d;
            addr_data_q  <= addr_data_d;
            addr_valid_q <= addr_valid_d;
            pay_data_q   <= pay_data_d;
            pay_valid_q  <= pay_valid_d;
            pay_index_q  <= pay_index_d;
            pay_last_q   <= pay_last_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            err_code_q   <= err_code_d;
`ifdef UART_FRAME_CHKSUM_EN
            chk_q        <= chk_d;
`endif
        end
    end

    assign addr_data  = addr_data_q;
    assign addr_valid = addr_valid_q;
    assign pay_data   = pay_data_q;
    assign pay_valid  = pay_valid_q;
    assign pay_index  = pay_index_q;
    assign pay_last   = pay_last_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign err_code   = err_code_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb_uart_frame_parser: directed bench for uart_frame_parser.
// Default build exercises the plain parser; with UART_FRAME_CHKSUM_EN it uses
// ADDR_BYTES=2 and exercises the checksum path.
module tb_uart_frame_parser;

`ifdef UART_FRAME_CHKSUM_EN
    localparam int AB = 2;
`else
    localparam int AB = 1;
`endif
    localparam int TO  = 20;
    localparam int MP  = 8;
    localparam int PIW = $clog2(MP + 1);

    logic              sys_clk;
    logic              sys_rst_n;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic [8*AB-1:0]   addr_data;
    logic              addr_valid;
    logic [7:0]        pay_data;
    logic              pay_valid;
    logic [PIW-1:0]    pay_index;
    logic              pay_last;
    logic              frame_done;
    logic              frame_err;
    logic [1:0]        err_code;

    int n_tests = 0;
    int n_fail  = 0;
    int err_pulses  = 0;
    int done_pulses = 0;

    uart_frame_parser #(
        .ADDR_BYTES     (AB),
        .MAX_PAYLOAD    (MP),
        .TIMEOUT_CYCLES (TO),
        .HEAD_FRAME     (8'hA6),
        .END_FRAME      (8'hCE)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .addr_data  (addr_data),
        .addr_valid (addr_valid),
        .pay_data   (pay_data),
        .pay_valid  (pay_valid),
        .pay_index  (pay_index),
        .pay_last   (pay_last),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .err_code   (err_code)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Pulse counters sampled on the inactive edge.
    always @(negedge sys_clk) begin
        if (frame_err)  err_pulses++;
        if (frame_done) done_pulses++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at negedge+1; drives one byte for one cycle and returns at the
    // following negedge+1, where the pulses caused by that byte are visible.
    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge sys_clk);
        rx_valid = 1'b0;
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sys_clk);
        #1;
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({addr_data, addr_valid, pay_data, pay_valid, pay_index,
                    pay_last, frame_done, frame_err, err_code});
    endfunction

`ifndef UART_FRAME_CHKSUM_EN
    task automatic good_frame(input string tag);
        send_byte(8'hA6); send_byte(8'h03); send_byte(8'h10);
        send_byte(8'h55); send_byte(8'hAA); send_byte(8'hCE);
        check(tag, frame_done, 1'b1);
    endtask
`endif

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        logic [1:0] code;
        int e0;

        sys_rst_n = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        idle(3);
        check("reset_outputs", all_outputs(), 64'd0);
        sys_rst_n = 1'b1;
        idle(2);
        check("post_reset_outputs", all_outputs(), 64'd0);

`ifndef UART_FRAME_CHKSUM_EN
        // Good frame A6 03 10 55 AA CE, with a stray byte before it.
        send_byte(8'h77);
        check("stray_no_err", frame_err, 1'b0);
        send_byte(8'hA6); send_byte(8'h03); send_byte(8'h10);
        check("good_addr_valid", addr_valid, 1'b1);
        check("good_addr_data", addr_data, 8'h10);
        send_byte(8'h55);
        check("good_pay0_valid", pay_valid, 1'b1);
        check("good_pay0_data", pay_data, 8'h55);
        check("good_pay0_index", pay_index, 0);
        check("good_pay0_last", pay_last, 1'b0);
        send_byte(8'hAA);
        check("good_pay1_data", pay_data, 8'hAA);
        check("good_pay1_index", pay_index, 1);
        check("good_pay1_last", pay_last, 1'b1);
        send_byte(8'hCE);
        check("good_done", frame_done, 1'b1);
        check("good_no_err", frame_err, 1'b0);
        check("good_addr_held", addr_data, 8'h10);

        // Illegal LEN above range (legal is 2..9), then a good frame.
        send_byte(8'hA6); send_byte(8'h0A);
        check("len_hi_err", frame_err, 1'b1);
        check("len_hi_code", err_code, 2'd0);
        good_frame("len_hi_recover_done");

        // LEN=1 below range, then back-to-back LEN=9 (maximum payload 8).
        send_byte(8'hA6); send_byte(8'h01);
        check("len_lo_err", frame_err, 1'b1);
        check("len_lo_code", err_code, 2'd0);
        send_byte(8'hA6); send_byte(8'h09); send_byte(8'h21);
        check("len9_addr", addr_data, 8'h21);
        for (int i = 0; i < 7; i++) send_byte(8'(i));
        check("len9_pay6_last", pay_last, 1'b0);
        send_byte(8'hF7);
        check("len9_pay7_index", pay_index, 7);
        check("len9_pay7_last", pay_last, 1'b1);
        check("len9_pay7_data", pay_data, 8'hF7);
        send_byte(8'hCE);
        check("len9_done", frame_done, 1'b1);

        // Bad tail A6 02 20 33 A6; the A6 must not open a frame, so 0A is ignored.
        send_byte(8'hA6); send_byte(8'h02); send_byte(8'h20); send_byte(8'h33);
        check("tail_pay_last", pay_last, 1'b1);
        send_byte(8'hA6);
        check("tail_err", frame_err, 1'b1);
        check("tail_code", err_code, 2'd1);
        check("tail_no_done", frame_done, 1'b0);
        send_byte(8'h0A);
        check("tail_a6_not_head", frame_err, 1'b0);
        check("tail_code_held", err_code, 2'd1);

        // Timeout: error exactly TO+1 cycles after the last byte.
        send_byte(8'hA6); send_byte(8'h02); send_byte(8'h20);
        seen = 0;
        code = 2'd0;
        for (int k = 1; k <= TO + 4; k++) begin
            @(negedge sys_clk);
            #1;
            if (frame_err && seen == 0) begin
                seen = k;
                code = err_code;
            end
        end
        check("timeout_latency", seen, TO + 1);
        check("timeout_code", code, 2'd2);

        // A byte on the expiry cycle wins over the timeout.
        e0 = err_pulses;
        send_byte(8'hA6); send_byte(8'h02); send_byte(8'h20);
        idle(TO);
        send_byte(8'h33);
        check("expiry_byte_no_err", frame_err, 1'b0);
        check("expiry_byte_pay", pay_valid, 1'b1);
        send_byte(8'hCE);
        check("expiry_byte_done", frame_done, 1'b1);
        check("expiry_byte_err_count", err_pulses - e0, 0);

        // Reset mid-payload.
        e0 = err_pulses;
        send_byte(8'hA6); send_byte(8'h03); send_byte(8'h10); send_byte(8'h55);
        check("rst_mid_pay_valid", pay_valid, 1'b1);
        sys_rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", all_outputs(), 64'd0);
        idle(2);
        sys_rst_n = 1'b1;
        idle(2);
        check("rst_mid_no_err", err_pulses - e0, 0);
        send_byte(8'hAA);
        check("rst_stray_ignored", pay_valid, 1'b0);
        good_frame("rst_recover_done");

        check("total_err_pulses", err_pulses, 4);
        check("total_done_pulses", done_pulses, 5);
`else
        // ADDR_BYTES=2: A6 03 12 34 56 CHK CE. XOR of 03,12,34,56 is 0x73.
        send_byte(8'hA6); send_byte(8'h03); send_byte(8'h12);
        check("chk_addr_not_yet", addr_valid, 1'b0);
        send_byte(8'h34);
        check("chk_addr_valid", addr_valid, 1'b1);
        check("chk_addr_data", addr_data, 16'h1234);
        send_byte(8'h56);
        check("chk_pay_data", pay_data, 8'h56);
        check("chk_pay_index", pay_index, 0);
        check("chk_pay_last", pay_last, 1'b1);
        send_byte(8'h73);
        check("chk_ok_no_err", frame_err, 1'b0);
        send_byte(8'hCE);
        check("chk_ok_done", frame_done, 1'b1);

        // Wrong checksum: error code 3, tail not awaited.
        send_byte(8'hA6); send_byte(8'h03); send_byte(8'h12);
        send_byte(8'h34); send_byte(8'h56); send_byte(8'h08);
        check("chk_bad_err", frame_err, 1'b1);
        check("chk_bad_code", err_code, 2'd3);
        send_byte(8'hCE);
        check("chk_bad_no_done", frame_done, 1'b0);
        check("chk_bad_no_err2", frame_err, 1'b0);

        // Reset mid-payload, then a clean frame.
        e0 = err_pulses;
        send_byte(8'hA6); send_byte(8'h04); send_byte(8'h12); send_byte(8'h34);
        send_byte(8'h56);
        sys_rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", all_outputs(), 64'd0);
        idle(2);
        sys_rst_n = 1'b1;
        idle(2);
        check("rst_mid_no_err", err_pulses - e0, 0);
        send_byte(8'hA6); send_byte(8'h03); send_byte(8'h12);
        send_byte(8'h34); send_byte(8'h56); send_byte(8'h73); send_byte(8'hCE);
        check("rst_recover_done", frame_done, 1'b1);

        check("total_err_pulses", err_pulses, 1);
        check("total_done_pulses", done_pulses, 2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
